// File: rtl/frog_pkg.sv
// Shared frogger constants and types: screen geometry, coordinate width,
// motion direction and the horizontal wrap-around step helper.
package frog_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 11;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } move_state_t;

    // One extra bit of headroom so x + speed can never overflow before the wrap.
    function automatic logic [COORD_W-1:0] wrap_move(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] spd,
        input dir_t               dir
    );
        logic [COORD_W:0] x_w;
        logic [COORD_W:0] s_w;
        logic [COORD_W:0] scr_w;
        logic [COORD_W:0] n;
        x_w   = {1'b0, x};
        s_w   = {1'b0, spd};
        scr_w = (COORD_W+1)'(SCREEN_W);
        if (dir == DIR_RIGHT) begin
            n = x_w + s_w;
            if (n >= scr_w) begin
                n = n - scr_w;
            end
        end else begin
            if (x_w < s_w) begin
                n = x_w + scr_w - s_w;
            end else begin
                n = x_w - s_w;
            end
        end
        return n[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/log_move_if.sv
// Frame-control inputs and sprite-position outputs of one river log.
interface log_move_if;
    import frog_pkg::*;

    logic                      startOfFrame;
    logic                      enable;
    logic                      restart;
    logic        [COORD_W-1:0] ObjectStartX;
    logic        [COORD_W-1:0] ObjectStartY;
    logic                      step;
    logic signed [COORD_W-1:0] carry_dx;

    modport master (
        output startOfFrame, enable, restart,
        input  ObjectStartX, ObjectStartY, step, carry_dx
    );

    modport slave (
        input  startOfFrame, enable, restart,
        output ObjectStartX, ObjectStartY, step, carry_dx
    );

endinterface

// File: rtl/log_step_timer.sv
// Frame counter for a log: pulses step_now on the frame that completes
// FRAMES_PER_STEP enabled frames.
module log_step_timer
    import frog_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 1
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic start_of_frame,
    input  logic enable,
    input  logic restart,
    output logic step_now
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES_PER_STEP - 1);

    move_state_t      state;
    logic [CNT_W-1:0] fcnt_q;
    logic [CNT_W-1:0] fcnt_d;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    // RUN/HOLD tracks enable in the same cycle, so the mode is not registered.
    always_comb begin
        fcnt_d   = fcnt_q;
        step_now = 1'b0;
        state    = enable ? ST_RUN : ST_HOLD;
        if (restart) begin
            fcnt_d = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (start_of_frame) begin
                        if (fcnt_q == LAST) begin
                            fcnt_d   = '0;
                            step_now = 1'b1;
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    fcnt_d = fcnt_q;
                end
            endcase
        end
    end

endmodule

// File: rtl/log_move.sv
// Horizontal position generator for one river log sprite, with wrap-around
// at the screen edge and a per-step displacement for a riding frog.
module log_move
    import frog_pkg::*;
#(
    parameter int unsigned START_X         = 0,
    parameter int unsigned START_Y         = 0,
    parameter int unsigned SPEED           = 4,
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter bit          DIRECTION       = 1'b0
) (
    input  logic       CLK,
    input  logic       RESETn,
    log_move_if.slave  bus
);

    localparam dir_t                      DIR     = dir_t'(DIRECTION);
    localparam logic        [COORD_W-1:0] X_START = COORD_W'(START_X);
    localparam logic        [COORD_W-1:0] SPD     = COORD_W'(SPEED);
    localparam logic signed [COORD_W-1:0] DX_STEP =
        (DIR == DIR_LEFT) ? -$signed(SPD) : $signed(SPD);

    logic                      step_now;
    logic        [COORD_W-1:0] x_q;
    logic        [COORD_W-1:0] x_d;
    logic                      step_q;
    logic                      step_d;
    logic signed [COORD_W-1:0] dx_q;
    logic signed [COORD_W-1:0] dx_d;

    log_step_timer #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_timer (
        .CLK            (CLK),
        .RESETn         (RESETn),
        .start_of_frame (bus.startOfFrame),
        .enable         (bus.enable),
        .restart        (bus.restart),
        .step_now       (step_now)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            x_q    <= X_START;
            step_q <= 1'b0;
            dx_q   <= '0;
        end else begin
            x_q    <= x_d;
            step_q <= step_d;
            dx_q   <= dx_d;
        end
    end

    // Restart outranks a step that the timer might report in the same cycle.
    always_comb begin
        x_d    = x_q;
        step_d = 1'b0;
        dx_d   = '0;
        if (bus.restart) begin
            x_d = X_START;
        end else if (step_now) begin
            x_d    = wrap_move(x_q, SPD, DIR);
            step_d = 1'b1;
            dx_d   = DX_STEP;
        end
    end

    assign bus.ObjectStartX = x_q;
    assign bus.ObjectStartY = COORD_W'(START_Y);
    assign bus.step         = step_q;
    assign bus.carry_dx     = dx_q;

endmodule

// File: tb/tb_log_move.sv
// Self-checking bench for log_move: four differently configured logs driven
// by directed and random frame traffic, compared against a modulo-arithmetic model.
module tb_log_move;

    localparam int NI = 4;

    logic CLK;
    logic RESETn;

    logic              sof [NI];
    logic              en  [NI];
    logic              rst [NI];
    logic [10:0]       ox  [NI];
    logic [10:0]       oy  [NI];
    logic              ostep [NI];
    logic signed [10:0] odx [NI];

    int mx [NI];
    int mc [NI];
    int mstep [NI];
    int mdx [NI];

    int checks;
    int errors;

    function automatic int cfg_sx(input int k);
        case (k)
            0: return 600;
            1: return 4;
            2: return 300;
            default: return 639;
        endcase
    endfunction

    function automatic int cfg_sy(input int k);
        case (k)
            0: return 100;
            1: return 200;
            2: return 50;
            default: return 479;
        endcase
    endfunction

    function automatic int cfg_spd(input int k);
        case (k)
            0: return 8;
            1: return 8;
            2: return 4;
            default: return 639;
        endcase
    endfunction

    function automatic int cfg_fps(input int k);
        case (k)
            0: return 2;
            1: return 1;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_left(input int k);
        case (k)
            0: return 0;
            1: return 1;
            2: return 0;
            default: return 1;
        endcase
    endfunction

    log_move_if if0 ();
    log_move_if if1 ();
    log_move_if if2 ();
    log_move_if if3 ();

    log_move #(.START_X(600), .START_Y(100), .SPEED(8), .FRAMES_PER_STEP(2), .DIRECTION(1'b0))
        u0 (.CLK(CLK), .RESETn(RESETn), .bus(if0));
    log_move #(.START_X(4), .START_Y(200), .SPEED(8), .FRAMES_PER_STEP(1), .DIRECTION(1'b1))
        u1 (.CLK(CLK), .RESETn(RESETn), .bus(if1));
    log_move #(.START_X(300), .START_Y(50), .SPEED(4), .FRAMES_PER_STEP(3), .DIRECTION(1'b0))
        u2 (.CLK(CLK), .RESETn(RESETn), .bus(if2));
    log_move #(.START_X(639), .START_Y(479), .SPEED(639), .FRAMES_PER_STEP(1), .DIRECTION(1'b1))
        u3 (.CLK(CLK), .RESETn(RESETn), .bus(if3));

    assign if0.startOfFrame = sof[0];
    assign if0.enable       = en[0];
    assign if0.restart      = rst[0];
    assign if1.startOfFrame = sof[1];
    assign if1.enable       = en[1];
    assign if1.restart      = rst[1];
    assign if2.startOfFrame = sof[2];
    assign if2.enable       = en[2];
    assign if2.restart      = rst[2];
    assign if3.startOfFrame = sof[3];
    assign if3.enable       = en[3];
    assign if3.restart      = rst[3];

    assign ox[0] = if0.ObjectStartX;
    assign oy[0] = if0.ObjectStartY;
    assign ostep[0] = if0.step;
    assign odx[0] = if0.carry_dx;
    assign ox[1] = if1.ObjectStartX;
    assign oy[1] = if1.ObjectStartY;
    assign ostep[1] = if1.step;
    assign odx[1] = if1.carry_dx;
    assign ox[2] = if2.ObjectStartX;
    assign oy[2] = if2.ObjectStartY;
    assign ostep[2] = if2.step;
    assign odx[2] = if2.carry_dx;
    assign ox[3] = if3.ObjectStartX;
    assign oy[3] = if3.ObjectStartY;
    assign ostep[3] = if3.step;
    assign odx[3] = if3.carry_dx;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one instance for one cycle; pulses drop back, enable is sticky.
    task automatic applyStimulus(input int k, input logic s, input logic e, input logic r);
        sof[k] = s;
        en[k]  = e;
        rst[k] = r;
        @(negedge CLK);
        sof[k] = 1'b0;
        rst[k] = 1'b0;
    endtask

    // Model: position advances by SPEED modulo the screen width once every
    // FRAMES_PER_STEP enabled frame pulses; restart and reset reload it.
    always @(posedge CLK or negedge RESETn) begin
        for (int k = 0; k < NI; k++) begin
            if (!RESETn || rst[k]) begin
                mx[k]    = cfg_sx(k);
                mc[k]    = 0;
                mstep[k] = 0;
                mdx[k]   = 0;
            end else if (sof[k] && en[k]) begin
                mc[k] = mc[k] + 1;
                if (mc[k] == cfg_fps(k)) begin
                    mc[k] = 0;
                    if (cfg_left(k) != 0) begin
                        mx[k]  = (mx[k] - cfg_spd(k) + 640) % 640;
                        mdx[k] = -cfg_spd(k);
                    end else begin
                        mx[k]  = (mx[k] + cfg_spd(k)) % 640;
                        mdx[k] = cfg_spd(k);
                    end
                    mstep[k] = 1;
                end else begin
                    mstep[k] = 0;
                    mdx[k]   = 0;
                end
            end else begin
                mstep[k] = 0;
                mdx[k]   = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if ($time > 0) begin
            for (int k = 0; k < NI; k++) begin
                checkOutput($sformatf("model_x[%0d]", k), int'(ox[k]), mx[k]);
                checkOutput($sformatf("model_y[%0d]", k), int'(oy[k]), cfg_sy(k));
                checkOutput($sformatf("model_step[%0d]", k), int'(ostep[k]), mstep[k]);
                checkOutput($sformatf("model_dx[%0d]", k), int'(odx[k]), mdx[k]);
            end
        end
    end

    initial begin
        int exp_x [5];
        int step_seen;
        checks = 0;
        errors = 0;
        for (int k = 0; k < NI; k++) begin
            sof[k] = 1'b0;
            en[k]  = 1'b0;
            rst[k] = 1'b0;
        end
        RESETn = 1'b1;
        #1 RESETn = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        checkOutput("reset_x0", int'(ox[0]), 600);
        checkOutput("reset_step0", int'(ostep[0]), 0);
        checkOutput("reset_dx0", int'(odx[0]), 0);

        $display("[TB] async reset mid-run");
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 1'b1, 1'b0);
        checkOutput("pre_reset_x0", int'(ox[0]), 616);
        #2 RESETn = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("async_x[%0d]", k), int'(ox[k]), cfg_sx(k));
            checkOutput($sformatf("async_y[%0d]", k), int'(oy[k]), cfg_sy(k));
            checkOutput($sformatf("async_step[%0d]", k), int'(ostep[k]), 0);
            checkOutput($sformatf("async_dx[%0d]", k), int'(odx[k]), 0);
        end
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);

        $display("[TB] right wrap, two frames per step");
        exp_x = '{608, 616, 624, 632, 0};
        step_seen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b1, 1'b1, 1'b0);
            step_seen = step_seen + int'(ostep[0]);
            if (i % 2 == 1) begin
                checkOutput("s1_x", int'(ox[0]), exp_x[i/2]);
                checkOutput("s1_dx", int'(odx[0]), 8);
            end else begin
                checkOutput("s1_nostep", int'(ostep[0]), 0);
            end
        end
        checkOutput("s1_step_count", step_seen, 5);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        checkOutput("s1_step_drop", int'(ostep[0]), 0);

        $display("[TB] left wrap, one frame per step");
        applyStimulus(1, 1'b1, 1'b1, 1'b0);
        checkOutput("s2_x_first", int'(ox[1]), 636);
        checkOutput("s2_dx", int'(odx[1]), -8);
        applyStimulus(1, 1'b1, 1'b1, 1'b0);
        checkOutput("s2_x_second", int'(ox[1]), 628);

        $display("[TB] enable freeze with three frames per step");
        applyStimulus(2, 1'b1, 1'b1, 1'b0);
        applyStimulus(2, 1'b1, 1'b1, 1'b0);
        checkOutput("s3_x_pending", int'(ox[2]), 300);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, 1'b1, 1'b0, 1'b0);
            checkOutput("s3_x_frozen", int'(ox[2]), 300);
            checkOutput("s3_step_frozen", int'(ostep[2]), 0);
        end
        applyStimulus(2, 1'b1, 1'b1, 1'b0);
        checkOutput("s3_x_resume", int'(ox[2]), 304);
        checkOutput("s3_step_resume", int'(ostep[2]), 1);

        $display("[TB] restart colliding with a due step");
        applyStimulus(2, 1'b1, 1'b1, 1'b0);
        applyStimulus(2, 1'b1, 1'b1, 1'b0);
        applyStimulus(2, 1'b1, 1'b1, 1'b1);
        checkOutput("s4_x_restart", int'(ox[2]), 300);
        checkOutput("s4_step_restart", int'(ostep[2]), 0);
        applyStimulus(2, 1'b1, 1'b1, 1'b0);
        applyStimulus(2, 1'b1, 1'b1, 1'b0);
        checkOutput("s4_x_fresh", int'(ox[2]), 300);
        applyStimulus(2, 1'b1, 1'b1, 1'b0);
        checkOutput("s4_x_after", int'(ox[2]), 304);

        $display("[TB] max speed boundary");
        applyStimulus(3, 1'b1, 1'b1, 1'b0);
        checkOutput("s5_x_first", int'(ox[3]), 0);
        applyStimulus(3, 1'b1, 1'b1, 1'b0);
        checkOutput("s5_x_second", int'(ox[3]), 1);

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NI; k++) begin
                sof[k] = ($urandom_range(0, 2) == 0);
                en[k]  = ($urandom_range(0, 3) != 0);
                rst[k] = ($urandom_range(0, 49) == 0);
            end
            if ($urandom_range(0, 199) == 0) begin
                #1 RESETn = 1'b0;
                #2 RESETn = 1'b1;
            end
            @(negedge CLK);
        end
        for (int k = 0; k < NI; k++) begin
            sof[k] = 1'b0;
            rst[k] = 1'b0;
        end
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/log_move.md
# log_move

Position generator for one river log sprite. It advances the log's top-left coordinate horizontally once every `FRAMES_PER_STEP` video frames and wraps it modulo the screen width. It sits directly upstream of the log sprite drawer and feeds its `ObjectStartX`/`ObjectStartY` inputs. It also tells the frog controller how far the log moved on each step, so a frog standing on the log can ride with it.

## Interface
- `START_X`, 0 — reset/restart X coordinate; must be < `SCREEN_W`
- `START_Y`, 0 — fixed Y coordinate (lane row)
- `SPEED`, 4 — pixels moved per step; 1..`SCREEN_W`-1
- `FRAMES_PER_STEP`, 1 — frames between steps; ≥1
- `DIRECTION`, 0 — 0 = move right (+X), 1 = move left (−X)
- `CLK` in 1 — pixel clock
- `RESETn` in 1 — reset RESETn, asynchronous, active-low; clock CLK
- `startOfFrame` in 1 — one-cycle pulse, once per video frame
- `enable` in 1 — 1 = log moves; 0 = freeze position and frame count
- `restart` in 1 — synchronous reload of start position and counter
- `ObjectStartX` out 11 — registered top-left X, range 0..`SCREEN_W`-1
- `ObjectStartY` out 11 — registered top-left Y, always `START_Y`
- `step` out 1 — one-cycle pulse on every position update
- `carry_dx` out 11 signed — +`SPEED` or −`SPEED` while `step`=1, else 0

## Operation
- Frame counter `fcnt` counts 0..`FRAMES_PER_STEP`-1.
  - Advances only on `startOfFrame` && `enable`.
- Step condition: `startOfFrame` && `enable` && `fcnt`==`FRAMES_PER_STEP`-1.
  - On a step, `fcnt` returns to 0.
- Right move: `n` = `x` + `SPEED`. If `n` ≥ `SCREEN_W`, then `x` ← `n` − `SCREEN_W`; else `x` ← `n`.
- Left move: if `x` < `SPEED`, then `x` ← `x` + `SCREEN_W` − `SPEED`; else `x` ← `x` − `SPEED`.
- Internal arithmetic is 12-bit unsigned, so the intermediate sum never overflows. The result is always < `SCREEN_W` (640).
- `restart` has priority over everything. It loads `x`=`START_X`, `fcnt`=0, `step`=0 and `carry_dx`=0, regardless of `enable` or `startOfFrame`.
- `enable`=0: `x` and `fcnt` hold their values. A pending count resumes exactly where it stopped.
- States:
  - RUN: `enable`=1.
  - HOLD: `enable`=0.
  - Transitions follow `enable` each cycle.
  - `restart` forces the reload from either state and does not change the state.

## Timing
- Reset values: `ObjectStartX`=`START_X`, `ObjectStartY`=`START_Y`, `step`=0, `carry_dx`=0, `fcnt`=0.
- Latency: for a qualifying `startOfFrame` in cycle N, the new `ObjectStartX` and `step`=1 and `carry_dx` appear in cycle N+1.
  - `step` and `carry_dx` return to 0 in N+2 unless another step qualifies.
- `startOfFrame` with `enable`=0 is ignored entirely; it is not queued.
- `restart` and a qualifying `startOfFrame` in the same cycle: restart wins, and no step occurs that frame.
- `RESETn` asserted mid-frame clears everything immediately (asynchronous). The first step after deassertion needs the full `FRAMES_PER_STEP` pulses.

## Structure
- Shared package `frog_pkg` holds:
  - `SCREEN_W`=640, `SCREEN_H`=480
  - `COORD_W`=11
  - enum `dir_t` {DIR_RIGHT, DIR_LEFT}
- One sub-module, `log_step_timer`: the frame counter. It outputs a one-cycle `step_now` and takes `enable`/`restart`.
- The position/wrap register stays in `log_move`.

## Test plan
- `START_X`=600, `SPEED`=8, `FRAMES_PER_STEP`=2, right, `enable`=1, 10 `startOfFrame` pulses → X sequence 608, 616, 624, 632, 0.
  - `step` is asserted 5 times, each with `carry_dx`=+8.
- `START_X`=4, `SPEED`=8, left, `FRAMES_PER_STEP`=1, one pulse → X=636, `carry_dx`=−8. Next pulse → X=628.
- `FRAMES_PER_STEP`=3: send 2 pulses, drop `enable` and send 3 pulses, raise `enable` and send 1 pulse.
  - Response: X unchanged until the final pulse, then exactly one step.
- Step due when `restart` and `startOfFrame` are asserted in the same cycle → X=`START_X`, `step`=0.
  - A subsequent step needs `FRAMES_PER_STEP` fresh pulses.
- `RESETn` low for 1 cycle mid-run after X has moved to 616 → all outputs at reset values within the same cycle; `ObjectStartY`=`START_Y` throughout.
